fft_iter_sequencer: RTL and testbench

FFT_ITER_SEQUENCER -- requirements
Module: fft_iter_sequencer

---
 rtl/fft_iter_pkg.sv | 32 +++
 rtl/fft_iter_addr_gen.sv | 33 +++
 rtl/fft_iter_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fft_iter_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_iter_pkg.sv
// rtl/fft_iter_pkg.sv - shared state type, latencies and width helpers for the FFT sequencer
package fft_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Butterfly slot length in cycles: read, strobe, write-back.
  localparam int BFLY_LAT   = 3;
  localparam int N_LOG2_DEF = 3;

  // Stage index width; at least one bit so the smallest FFT still has a port.
  function automatic int stg_wl(input int n_log2);
    return (n_log2 < 2) ? 1 : $clog2(n_log2);
  endfunction

  // Data-RAM address width.
  function automatic int addr_w(input int n_log2);
    return n_log2;
  endfunction

  // Twiddle-ROM address width (N/2 entries).
  function automatic int tw_w(input int n_log2);
    return n_log2 - 1;
  endfunction

  localparam int STG_WL = stg_wl(N_LOG2_DEF);

endpackage

// File: rtl/fft_iter_addr_gen.sv
// rtl/fft_iter_addr_gen.sv - butterfly operand and twiddle address generator for stage s, butterfly j
module fft_iter_addr_gen
  import fft_iter_pkg::*;
#(
  parameter int N_LOG2 = 3
) (
  input  logic [stg_wl(N_LOG2)-1:0] s,
  input  logic [tw_w(N_LOG2)-1:0]   j,
  output logic [addr_w(N_LOG2)-1:0] addr_a,
  output logic [addr_w(N_LOG2)-1:0] addr_b,
  output logic [tw_w(N_LOG2)-1:0]   tw_addr
);

  localparam int AW = addr_w(N_LOG2);
  localparam int TW = tw_w(N_LOG2);

  logic [AW-1:0] jw;
  logic [AW-1:0] span;
  logic [AW-1:0] mask;
  logic [AW-1:0] low;

  // Split j at bit s: high part moves up one bit to open the gap for the partner at +span.
  always_comb begin
    jw      = AW'(j);
    span    = AW'(1) << s;
    mask    = span - AW'(1);
    low     = jw & mask;
    addr_a  = ((jw & ~mask) << 1) | low;
    addr_b  = addr_a | span;
    tw_addr = (int'(s) > TW) ? '0 : TW'(low << (TW - int'(s)));
  end

endmodule

// File: rtl/fft_iter_sequencer.sv
// rtl/fft_iter_sequencer.sv - in-place radix-2 FFT sequencer; FFT_ITER_SEQ_ABORT_EN adds an abort input
module fft_iter_sequencer
  import fft_iter_pkg::*;
#(
  parameter int N_LOG2     = 3,
  parameter int RAM_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef FFT_ITER_SEQ_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [stg_wl(N_LOG2)-1:0] stage,
  output logic                      rd_en,
  output logic [addr_w(N_LOG2)-1:0] rd_addr_a,
  output logic [addr_w(N_LOG2)-1:0] rd_addr_b,
  output logic [tw_w(N_LOG2)-1:0]   tw_addr,
  output logic                      bf_strb,
  output logic                      wr_en,
  output logic [addr_w(N_LOG2)-1:0] wr_addr_a,
  output logic [addr_w(N_LOG2)-1:0] wr_addr_b
);

  localparam int SW = stg_wl(N_LOG2);
  localparam int AW = addr_w(N_LOG2);
  localparam int TW = tw_w(N_LOG2);

  // Strobe follows the read by the RAM latency; the last phase of a slot is write-back.
  localparam logic [1:0]    PH_STRB = 2'(RAM_RD_LAT);
  localparam logic [1:0]    PH_LAST = 2'(BFLY_LAT - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(N_LOG2 - 1);

  seq_state_t    state;
  logic [1:0]    ph;
  logic [SW-1:0] s;
  logic [TW-1:0] j;
  logic          last_bfly;
  logic          have_prev;
  logic [AW-1:0] pend_a;
  logic [AW-1:0] pend_b;
  logic [1:0]    ph_nx;
  logic [SW-1:0] gen_s;
  logic [AW-1:0] gen_a;
  logic [AW-1:0] gen_b;
  logic [TW-1:0] gen_tw;
  logic          abort_hit;

`ifdef FFT_ITER_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign ph_nx = ph + 2'd1;
  // j already points at the next butterfly; during FLUSH it has wrapped to 0 for the next stage.
  assign gen_s = (state == ST_FLUSH) ? s + SW'(1) : s;
  assign stage = s;

  fft_iter_addr_gen #(
    .N_LOG2 (N_LOG2)
  ) u_addr_gen (
    .s       (gen_s),
    .j       (j),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  // Sequencer FSM: slot phase counter, stage/butterfly counters, write pipeline and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ph        <= 2'd0;
      s         <= '0;
      j         <= '0;
      last_bfly <= 1'b0;
      have_prev <= 1'b0;
      pend_a    <= '0;
      pend_b    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      bf_strb   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      rd_en   <= 1'b0;
      bf_strb <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            ph        <= 2'd0;
            busy      <= 1'b1;
            have_prev <= 1'b0;
            rd_en     <= 1'b1;
            rd_addr_a <= gen_a;
            rd_addr_b <= gen_b;
            tw_addr   <= gen_tw;
            j         <= j + TW'(1);
            last_bfly <= (j == {TW{1'b1}});
          end
        end
        ST_RUN, ST_FLUSH: begin
          if (abort_hit) begin
            state     <= ST_IDLE;
            ph        <= 2'd0;
            s         <= '0;
            j         <= '0;
            last_bfly <= 1'b0;
            have_prev <= 1'b0;
            busy      <= 1'b0;
          end else if (ph != PH_LAST) begin
            ph <= ph_nx;
            if (ph_nx == PH_STRB) begin
              bf_strb <= 1'b1;
            end
            if (ph_nx == PH_LAST) begin
              // Retire the previous slot's butterfly, then remember this slot's pair.
              if (have_prev) begin
                wr_en     <= 1'b1;
                wr_addr_a <= pend_a;
                wr_addr_b <= pend_b;
              end
              pend_a    <= rd_addr_a;
              pend_b    <= rd_addr_b;
              have_prev <= 1'b1;
            end
          end else begin
            ph <= 2'd0;
            if (state == ST_RUN) begin
              if (last_bfly) begin
                state <= ST_FLUSH;
              end else begin
                rd_en     <= 1'b1;
                rd_addr_a <= gen_a;
                rd_addr_b <= gen_b;
                tw_addr   <= gen_tw;
                j         <= j + TW'(1);
                last_bfly <= (j == {TW{1'b1}});
              end
            end else if (s == S_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              // Next stage reads only after this stage's final write-back.
              state     <= ST_RUN;
              s         <= s + SW'(1);
              have_prev <= 1'b0;
              rd_en     <= 1'b1;
              rd_addr_a <= gen_a;
              rd_addr_b <= gen_b;
              tw_addr   <= gen_tw;
              j         <= j + TW'(1);
              last_bfly <= (j == {TW{1'b1}});
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          s         <= '0;
          j         <= '0;
          last_bfly <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_sequencer.sv
// tb/tb_fft_iter_sequencer.sv - self-checking bench for fft_iter_sequencer (N_LOG2=3)
module tb_fft_iter_sequencer;
  import fft_iter_pkg::*;

  localparam int NCYC = 60;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy;
  logic                done;
  logic [STG_WL-1:0]   stage;
  logic                rd_en;
  logic [2:0]          rd_addr_a;
  logic [2:0]          rd_addr_b;
  logic [1:0]          tw_addr;
  logic                bf_strb;
  logic                wr_en;
  logic [2:0]          wr_addr_a;
  logic [2:0]          wr_addr_b;
`ifdef FFT_ITER_SEQ_ABORT_EN
  logic                abort;
  int                  abort_at;
`endif

  fft_iter_sequencer #(
    .N_LOG2     (3),
    .RAM_RD_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FFT_ITER_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bf_strb   (bf_strb),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int j;
    int a;
    int b;
    int tw;
  } vec_t;

  vec_t tbl [12];

  int c_busy  [NCYC];
  int c_done  [NCYC];
  int c_stage [NCYC];
  int c_rd    [NCYC];
  int c_ra    [NCYC];
  int c_rb    [NCYC];
  int c_tw    [NCYC];
  int c_bf    [NCYC];
  int c_wr    [NCYC];
  int c_wa    [NCYC];
  int c_wb    [NCYC];

  int errors = 0;
  int checks = 0;

  // Behavioral data RAM (read latency 1) and 3-cycle butterfly with 1/2 scaling per stage.
  typedef struct packed {
    int r1;
    int i1;
    int r2;
    int i2;
  } bf_t;

  logic ram_init = 1'b0;
  int   ram_re [8];
  int   ram_im [8];
  int   xa_re, xa_im, xb_re, xb_im;
  logic [1:0] tw_q;
  bf_t  st1, st2, dout;
  logic v1, v2;

  function automatic bf_t bfly(input int xr, input int xi, input int yr, input int yi,
                               input logic [1:0] t);
    int  wr, wi, tr, ti;
    bf_t r;
    case (t)
      2'd0: begin wr = 16384;  wi = 0;      end
      2'd1: begin wr = 11585;  wi = -11585; end
      2'd2: begin wr = 0;      wi = -16384; end
      default: begin wr = -11585; wi = -11585; end
    endcase
    tr   = (yr * wr - yi * wi) >>> 14;
    ti   = (yr * wi + yi * wr) >>> 14;
    r.r1 = (xr + tr) >>> 1;
    r.i1 = (xi + ti) >>> 1;
    r.r2 = (xr - tr) >>> 1;
    r.i2 = (xi - ti) >>> 1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 8; i++) begin
        ram_re[i] <= (i == 0) ? 800 : 0;
        ram_im[i] <= 0;
      end
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (rd_en) begin
        xa_re <= ram_re[rd_addr_a];
        xa_im <= ram_im[rd_addr_a];
        xb_re <= ram_re[rd_addr_b];
        xb_im <= ram_im[rd_addr_b];
        tw_q  <= tw_addr;
      end
      if (bf_strb) st1 <= bfly(xa_re, xa_im, xb_re, xb_im, tw_q);
      v1 <= bf_strb;
      if (v1) st2 <= st1;
      v2 <= v1;
      if (v2) dout <= st2;
      if (wr_en) begin
        ram_re[wr_addr_a] <= dout.r1;
        ram_im[wr_addr_a] <= dout.i1;
        ram_re[wr_addr_b] <= dout.r2;
        ram_im[wr_addr_b] <= dout.i2;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start in cycle 0 and record outputs for cycles 1..NCYC-1.
  task automatic capture_run(input int restart_cyc, input int rst_cyc);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k < NCYC; k++) begin
      @(negedge clk);
      c_busy[k]  = int'(busy);
      c_done[k]  = int'(done);
      c_stage[k] = int'(stage);
      c_rd[k]    = int'(rd_en);
      c_ra[k]    = int'(rd_addr_a);
      c_rb[k]    = int'(rd_addr_b);
      c_tw[k]    = int'(tw_addr);
      c_bf[k]    = int'(bf_strb);
      c_wr[k]    = int'(wr_en);
      c_wa[k]    = int'(wr_addr_a);
      c_wb[k]    = int'(wr_addr_b);
      start      = (k == restart_cyc);
      rst        = (k == rst_cyc);
`ifdef FFT_ITER_SEQ_ABORT_EN
      abort      = (k == abort_at);
`endif
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_full_run(input string tag);
    int cyc;
    int n_rd, n_wr, n_bf, n_done, done_at, both;
    n_rd = 0; n_wr = 0; n_bf = 0; n_done = 0; done_at = -1; both = 0;
    for (int k = 0; k < 12; k++) begin
      cyc = 1 + tbl[k].s * 15 + tbl[k].j * 3;
      chk($sformatf("%s rd_en k%0d", tag, k), c_rd[cyc], 1);
      chk($sformatf("%s rd_a k%0d", tag, k), c_ra[cyc], tbl[k].a);
      chk($sformatf("%s rd_b k%0d", tag, k), c_rb[cyc], tbl[k].b);
      chk($sformatf("%s tw k%0d", tag, k), c_tw[cyc], tbl[k].tw);
      chk($sformatf("%s stage k%0d", tag, k), c_stage[cyc], tbl[k].s);
      chk($sformatf("%s bf_strb k%0d", tag, k), c_bf[cyc + 1], 1);
      chk($sformatf("%s rd_a_hold k%0d", tag, k), c_ra[cyc + 2], tbl[k].a);
      chk($sformatf("%s wr_en k%0d", tag, k), c_wr[cyc + 5], 1);
      chk($sformatf("%s wr_a k%0d", tag, k), c_wa[cyc + 5], tbl[k].a);
      chk($sformatf("%s wr_b k%0d", tag, k), c_wb[cyc + 5], tbl[k].b);
    end
    for (int k = 1; k < NCYC; k++) begin
      n_rd += c_rd[k];
      n_wr += c_wr[k];
      n_bf += c_bf[k];
      n_done += c_done[k];
      if (c_done[k] == 1 && done_at < 0) done_at = k;
      if (c_rd[k] == 1 && c_wr[k] == 1) both++;
    end
    chk($sformatf("%s rd_count", tag), n_rd, 12);
    chk($sformatf("%s wr_count", tag), n_wr, 12);
    chk($sformatf("%s bf_count", tag), n_bf, 15);
    chk($sformatf("%s done_count", tag), n_done, 1);
    chk($sformatf("%s done_cycle", tag), done_at, 46);
    chk($sformatf("%s rd_wr_overlap", tag), both, 0);
    chk($sformatf("%s busy_c1", tag), c_busy[1], 1);
    chk($sformatf("%s busy_c45", tag), c_busy[45], 1);
    chk($sformatf("%s busy_c47", tag), c_busy[47], 0);
    chk($sformatf("%s stage_idle", tag), c_stage[50], 0);
  endtask

  initial begin
    int act;
    tbl[0]  = '{0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 2, 3, 0};
    tbl[2]  = '{0, 2, 4, 5, 0};
    tbl[3]  = '{0, 3, 6, 7, 0};
    tbl[4]  = '{1, 0, 0, 2, 0};
    tbl[5]  = '{1, 1, 1, 3, 2};
    tbl[6]  = '{1, 2, 4, 6, 0};
    tbl[7]  = '{1, 3, 5, 7, 2};
    tbl[8]  = '{2, 0, 0, 4, 0};
    tbl[9]  = '{2, 1, 1, 5, 1};
    tbl[10] = '{2, 2, 2, 6, 2};
    tbl[11] = '{2, 3, 3, 7, 3};

    rst   = 1'b1;
    start = 1'b0;
`ifdef FFT_ITER_SEQ_ABORT_EN
    abort    = 1'b0;
    abort_at = -1;
`endif
    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset rd_en", int'(rd_en), 0);
    chk("reset wr_en", int'(wr_en), 0);
    chk("reset bf_strb", int'(bf_strb), 0);
    chk("reset stage", int'(stage), 0);
    chk("reset rd_addr", int'({rd_addr_a, rd_addr_b, tw_addr}), 0);
    chk("reset wr_addr", int'({wr_addr_a, wr_addr_b}), 0);
    rst      = 1'b0;
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;

    // Plain run with data model: impulse in, flat spectrum scaled by 1/8 out.
    capture_run(-1, -1);
    check_full_run("run1");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("model re[%0d]", i), ram_re[i], 100);
      chk($sformatf("model im[%0d]", i), ram_im[i], 0);
    end

    // Start re-asserted mid-run must not disturb anything.
    capture_run(10, -1);
    check_full_run("restart");

    // Reset mid-run in stage 1, then a fresh full run.
    capture_run(-1, 20);
    chk("rst busy", c_busy[21], 0);
    chk("rst done", c_done[21], 0);
    chk("rst rd_en", c_rd[21], 0);
    chk("rst wr_en", c_wr[21], 0);
    chk("rst bf_strb", c_bf[21], 0);
    chk("rst stage", c_stage[21], 0);
    chk("rst rd_addr", c_ra[21] + c_rb[21] + c_tw[21], 0);
    chk("rst wr_addr", c_wa[21] + c_wb[21], 0);
    act = 0;
    for (int k = 21; k < NCYC; k++) act += c_rd[k] + c_wr[k] + c_bf[k] + c_done[k] + c_busy[k];
    chk("rst quiet", act, 0);
    capture_run(-1, -1);
    check_full_run("after_rst");

`ifdef FFT_ITER_SEQ_ABORT_EN
    // Abort during stage 1, phase 1 (cycle 17).
    abort_at = 17;
    capture_run(-1, -1);
    abort_at = -1;
    chk("abort bf_c17", c_bf[17], 1);
    chk("abort stage_c17", c_stage[17], 1);
    chk("abort busy_c18", c_busy[18], 0);
    act = 0;
    for (int k = 18; k < NCYC; k++) act += c_wr[k] + c_bf[k] + c_done[k] + c_rd[k];
    chk("abort quiet", act, 0);
    capture_run(-1, -1);
    check_full_run("after_abort");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
